div_seq: RTL and testbench

//  Iterative radix-2 restoring divider sequencer serving the EX stage DIV/DIVU ops.
//  EX holds start_i with operands while ready_o=0 (raising its stall request).
//  div_seq runs one quotient bit per cycle and returns {remainder, quotient} for HI/LO.

---
 rtl/div_seq.sv | 161 ++++++++++++++++
 tb/tb_div_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: iterative radix-2 restoring divider for DIV/DIVU.
// Produces one quotient bit per cycle on operand magnitudes, then applies
// the two's complement sign fix-up and returns {remainder, quotient}.

module div_seq #(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                annul_i,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   typedef enum logic [1:0] {
      ST_FREE,
      ST_BYZERO,
      ST_ON,
      ST_END
   } state_t;

   localparam int                CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] dvd;
   logic [DATA_W-1:0] dsr;
   logic [DATA_W-1:0] rem;
   logic              neg_quo;
   logic              neg_rem;

   logic              abort;
   logic              accept;
   logic              zero_div;
   logic              op1_neg;
   logic              op2_neg;
   logic [DATA_W-1:0] mag1;
   logic [DATA_W-1:0] mag2;
   logic [DATA_W:0]   trial;
   logic [DATA_W-1:0] diff;
   logic              fits;
   logic [DATA_W-1:0] quo_fix;
   logic [DATA_W-1:0] rem_fix;

   // Handshake decode, operand magnitudes, one restoring step and sign fix-up.
   always_comb begin
      abort    = annul_i | ~start_i;
      accept   = start_i & ~annul_i;
      zero_div = (opdata2_i == '0);
      op1_neg  = signed_div_i & opdata1_i[DATA_W-1];
      op2_neg  = signed_div_i & opdata2_i[DATA_W-1];
      mag1     = op1_neg ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
      mag2     = op2_neg ? (~opdata2_i + DATA_W'(1)) : opdata2_i;
      trial    = {rem, dvd[DATA_W-1]};
      fits     = (trial >= {1'b0, dsr});
      diff     = trial[DATA_W-1:0] - dsr;
      quo_fix  = neg_quo ? (~dvd + DATA_W'(1)) : dvd;
      rem_fix  = neg_rem ? (~rem + DATA_W'(1)) : rem;
   end

   // State register; reset forces the sequencer back to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_FREE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; annul wins over start everywhere, dropping start aborts.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_FREE: begin
            if (accept) begin
               state_nxt = zero_div ? ST_BYZERO : ST_ON;
            end
         end
         ST_BYZERO: begin
            state_nxt = abort ? ST_FREE : ST_END;
         end
         ST_ON: begin
            if (abort) begin
               state_nxt = ST_FREE;
            end else if (cnt == LAST) begin
               state_nxt = ST_END;
            end
         end
         ST_END: begin
            if (abort) begin
               state_nxt = ST_FREE;
            end
         end
         default: state_nxt = ST_FREE;
      endcase
   end

   // Datapath and registered outputs; the dividend register doubles as the
   // quotient shift register, so after DATA_W steps it holds the raw quotient.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         dvd      <= '0;
         dsr      <= '0;
         rem      <= '0;
         neg_quo  <= 1'b0;
         neg_rem  <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            ST_FREE: begin
               ready_o  <= 1'b0;
               result_o <= '0;
               if (accept && !zero_div) begin
                  cnt     <= '0;
                  dvd     <= mag1;
                  dsr     <= mag2;
                  rem     <= '0;
                  neg_quo <= op1_neg ^ op2_neg;
                  neg_rem <= op1_neg;
               end
            end
            ST_BYZERO: begin
               if (!abort) begin
                  result_o <= '0;
               end
            end
            ST_ON: begin
               if (!abort) begin
                  if (cnt == LAST) begin
                     result_o <= {rem_fix, quo_fix};
                  end else begin
                     rem <= fits ? diff : trial[DATA_W-1:0];
                     dvd <= {dvd[DATA_W-2:0], fits};
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            ST_END: begin
               if (abort) begin
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end else begin
                  ready_o <= 1'b1;
               end
            end
            default: begin
               ready_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq.
// A plain-arithmetic model gives the expected {rem, quo}; a per-cycle compare
// process checks ready_o timing and result_o against the current expectation.

module tb_div_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_i;
   logic         annul_i;
   logic         signed_div_i;
   logic [W-1:0] opdata1_i;
   logic [W-1:0] opdata2_i;
   logic [63:0]  result_o;
   logic         ready_o;

   int           pass_cnt = 0;
   int           total_cnt = 0;
   bit           chk_en = 1'b0;
   bit           exp_ready = 1'b0;
   bit           exp_zero = 1'b0;
   logic [63:0]  exp_result = '0;

   div_seq #(.DATA_W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected {remainder, quotient} from ordinary integer division.
   function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
      longint sa;
      longint sb;
      longint q;
      longint r;
      if (b == '0) return 64'd0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Per-cycle compare against the current expectation, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check_output("ready_o", 64'(ready_o), 64'(exp_ready));
         if (exp_ready) check_output("result_o", result_o, exp_result);
         else if (exp_zero) check_output("result_o_idle", result_o, 64'd0);
      end
   end

   // One division request. Called just after a rising edge; returns just after
   // a rising edge with start_i low and the sequencer expected idle.
   // abort_k>0 aborts before edge abort_k after acceptance (annul or start drop).
   task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                                 input logic [63:0] lit, input int abort_k, input bit by_annul,
                                 input int hold_n);
      logic [63:0] exp_val;
      int          lat;
      exp_val      = model(a, b, sgn);
      lat          = (b == '0) ? 2 : W + 2;
      start_i      = 1'b1;
      annul_i      = 1'b0;
      opdata1_i    = a;
      opdata2_i    = b;
      signed_div_i = sgn;
      exp_ready    = 1'b0;
      exp_zero     = 1'b1;
      exp_result   = exp_val;
      if (abort_k == 0) check_output("model_literal", exp_val, lit);
      @(posedge clk); #1;
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = ~sgn;
      for (int k = 1; k <= lat; k++) begin
         if (k == abort_k) begin
            if (by_annul) annul_i = 1'b1;
            else start_i = 1'b0;
         end
         @(posedge clk); #1;
         if (k == abort_k) begin
            annul_i   = 1'b0;
            start_i   = 1'b0;
            exp_ready = 1'b0;
            exp_zero  = 1'b1;
            @(posedge clk); #1;
            return;
         end
         exp_ready = (k == lat);
         exp_zero  = (k < lat - 1);
      end
      repeat (hold_n) begin
         @(posedge clk); #1;
      end
      check_output("result_literal", result_o, lit);
      start_i = 1'b0;
      @(posedge clk); #1;
      exp_ready = 1'b0;
      exp_zero  = 1'b1;
   endtask

   // Directed sequence: reset, arithmetic cases, divide-by-zero, aborts, reset mid-run.
   initial begin
      rst          = 1'b1;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_ready", 64'(ready_o), 64'd0);
      check_output("reset_result", result_o, 64'd0);
      rst      = 1'b0;
      exp_zero = 1'b1;
      chk_en   = 1'b1;
      @(posedge clk); #1;

      apply_stimulus(32'd100,       32'd7,         1'b0, {32'd2, 32'd14}, 0, 1'b0, 0);
      apply_stimulus(32'hFFFFFF9C,  32'd7,         1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, 0, 1'b0, 0);
      apply_stimulus(32'd100,       32'hFFFFFFF9,  1'b1, {32'd2, 32'hFFFFFFF2}, 0, 1'b0, 0);
      apply_stimulus(32'h80000000,  32'hFFFFFFFF,  1'b1, {32'd0, 32'h80000000}, 0, 1'b0, 0);
      apply_stimulus(32'hFFFFFFFF,  32'd1,         1'b0, {32'd0, 32'hFFFFFFFF}, 0, 1'b0, 0);
      apply_stimulus(32'h80000000,  32'hFFFFFFFF,  1'b0, {32'h80000000, 32'd0}, 0, 1'b0, 0);
      apply_stimulus(32'hFFFFFFF9,  32'd2,         1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 1'b0, 0);
      apply_stimulus(32'd12345,     32'd0,         1'b0, 64'd0, 0, 1'b0, 0);
      apply_stimulus(32'h80000000,  32'd0,         1'b1, 64'd0, 0, 1'b0, 0);
      apply_stimulus(32'd1000,      32'd3,         1'b0, {32'd1, 32'd333}, 0, 1'b0, 2);

      apply_stimulus(32'd5000,      32'd7,         1'b0, 64'd0, 10, 1'b1, 0);
      apply_stimulus(32'd9,         32'd3,         1'b0, {32'd0, 32'd3}, 0, 1'b0, 0);
      apply_stimulus(32'd4242,      32'd11,        1'b1, 64'd0, 20, 1'b0, 0);
      apply_stimulus(32'd55,        32'd0,         1'b0, 64'd0, 1, 1'b1, 0);
      apply_stimulus(32'd9,         32'd3,         1'b1, {32'd0, 32'd3}, 0, 1'b0, 0);

      start_i      = 1'b1;
      opdata1_i    = 32'd77;
      opdata2_i    = 32'd5;
      signed_div_i = 1'b0;
      repeat (16) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      check_output("rst_mid_ready", 64'(ready_o), 64'd0);
      check_output("rst_mid_result", result_o, 64'd0);
      rst     = 1'b0;
      start_i = 1'b0;
      @(posedge clk); #1;
      apply_stimulus(32'd77,        32'd5,         1'b0, {32'd2, 32'd15}, 0, 1'b0, 0);

      chk_en = 1'b0;
      $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
